interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  - Collects up to N_IRQ peripheral interrupt lines and feeds the CPU's single intr/int_ack pair.
//  - Latches requests, applies a mask and picks the highest-priority request.
//  - Holds one interrupt in service until software writes EOI.
//  - Sits on the I/O bus beside the I/O module; software reads the vector and writes EOI through io_cs/io_rd/io_wr.
// PARAMETERS
//  N_IRQ    8   number of interrupt lines, 1..32; index 0 has the highest priority
//  ID_W     5   width of the encoded interrupt id
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  irq       in   N_IRQ  peripheral requests, synchronous to clk
//  intr      out  1      interrupt request to CPU
//  int_ack   in   1      CPU acknowledge, one-cycle pulse
//  io_cs     in   1      controller select
//  io_rd     in   1      read strobe
//  io_wr     in   1      write strobe
//  io_addr   in   5      byte address; register index = io_addr[4:2]
//  io_din    in   32     write data
//  io_dout   out  32     read data
// BEHAVIOUR
//  - Reset: intr=0, io_dout=0, PENDING=0, MASK=0 (all enabled), VECTOR=0, state=IDLE, irq_q=0.
//  - Edge capture
//    - irq_q <= irq every cycle.
//    - A rising edge (irq & ~irq_q) sets the PENDING bit.
//    - Set wins over a same-cycle W1C clear of that bit.
//  - Eligible set: elig = PENDING & ~MASK.
//    - winner = lowest set index of elig.
//    - none = (elig == 0).
//  - Register map (index)
//    - 0 PENDING: read; write-1-to-clear.
//    - 1 MASK: read/write; 1 = masked.
//    - 2 VECTOR: read only; {in_svc, 26'b0, id}.
//    - 3 EOI: write only; data ignored.
//    - 4 TRIG: only with INTC_TRIGMODE_EN.
//    - Unmapped reads return 0; unmapped writes are ignored.
//  - io_dout is combinational: the register value when io_cs & io_rd, else 0.
//  - A write takes effect on the clk edge where io_cs & io_wr.
//  - FSM: IDLE, REQ, SVC.
//    - IDLE: when elig != 0, go to REQ next edge; intr = 1 from the following cycle. Latency is 1 cycle from PENDING set to intr.
//    - REQ, int_ack=1: VECTOR <= {1, winner}; clear PENDING[winner]; intr <= 0; go to SVC.
//      - The winner is evaluated in the ack cycle, so a higher-priority arrival before ack preempts.
//    - REQ, elig becomes 0 (masked or cleared) without ack: intr <= 0; go to IDLE.
//    - REQ, int_ack and elig == 0 in the same cycle: no service; go to IDLE.
//    - SVC: intr stays 0; new edges keep accumulating in PENDING.
//    - SVC, EOI write: VECTOR[31] <= 0; go to IDLE. Re-request is 1 cycle later if elig != 0.
//    - int_ack outside REQ and EOI outside SVC are ignored.
//  - Reset mid-service: all state is dropped asynchronously; in-flight requests are lost.
// CONFIGURATION
//  - Macro INTC_TRIGMODE_EN
//    - Defined: adds TRIG register at index 4 (read/write, reset 0; bit = 1 means level mode for that line).
//      - For level lines, PENDING[i] tracks irq[i] each cycle.
//      - For level lines, W1C and ack-clear have no effect; the source must drop irq before EOI.
//    - Undefined: every line is edge-triggered; index 4 reads 0 and writes are ignored.
// STRUCTURE
//  - Shared include intc_defs.vh:
//    - Register indices INTC_PEND, INTC_MASK, INTC_VEC, INTC_EOI, INTC_TRIG.
//    - State encodings S_IDLE, S_REQ, S_SVC.
//  - Sub-module intc_prio_enc: parameterised lowest-index priority encoder producing {none, id}.
// TESTING
//  - Reset: hold reset=0 while irq pulses -> intr=0, all reads 0. Release -> PENDING=0.
//  - Single: rising edge on irq[3] -> PENDING=0x08; intr=1 two cycles later.
//    - int_ack -> VECTOR=0x8000_0003, PENDING=0, intr=0.
//    - EOI -> VECTOR=0x0000_0003.
//  - Priority: edges on irq[5] and irq[1] together -> ack latches id 1.
//    - EOI -> intr reasserts and the next ack latches id 5.
//  - Mask: MASK=0x04, edge on irq[2] -> PENDING=0x04, intr stays 0.
//    - MASK=0 -> intr=1 next cycle.
//    - Setting MASK=0x04 again while in REQ -> intr drops, state returns to IDLE.
//  - W1C race: write PENDING=0x01 in the same cycle as a new edge on irq[0] -> PENDING[0] stays 1.
//  - INTC_TRIGMODE_EN: TRIG=0x80, hold irq[7]=1.
//    - Ack, then EOI -> intr reasserts.
//    - Drop irq[7] -> PENDING[7]=0, intr clears.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for interrupt_controller: register indices and FSM state encoding.
package interrupt_controller_pkg;

  localparam logic [2:0] INTC_PEND = 3'd0;
  localparam logic [2:0] INTC_MASK = 3'd1;
  localparam logic [2:0] INTC_VEC  = 3'd2;
  localparam logic [2:0] INTC_EOI  = 3'd3;
  localparam logic [2:0] INTC_TRIG = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  // Registers are word-spaced on the byte-addressed I/O bus.
  function automatic logic [2:0] reg_index(input logic [4:0] byte_addr);
    return byte_addr[4:2];
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder; none is set when no request is present.
module intc_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    req,
  output logic            none,
  output logic [ID_W-1:0] id
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

  assign none = ~|req;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing, maskable, fixed-priority interrupt controller with a bus-visible vector/EOI.
// Optional per-line level mode (TRIG register) is enabled with the INTC_TRIGMODE_EN macro.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  output logic             intr,
  input  logic             int_ack,
  input  logic             io_cs,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [4:0]       io_addr,
  input  logic [31:0]      io_din,
  output logic [31:0]      io_dout
);

  logic [N_IRQ-1:0] irq_q_reg;
  logic [N_IRQ-1:0] pending_reg;
  logic [N_IRQ-1:0] pending_next;
  logic [N_IRQ-1:0] mask_reg;
  logic [N_IRQ-1:0] level_mode;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  vec_id_reg;
  logic             in_svc_reg;
  logic             none;
  logic             ack_fire;
  logic             wr_en;
  logic             eoi_wr;
  logic [2:0]       reg_idx;
  logic [31:0]      rd_data;
  state_t           state_reg;
  logic             unused_bits;

  assign reg_idx  = reg_index(io_addr);
  assign wr_en    = io_cs & io_wr;
  assign eoi_wr   = wr_en && (reg_idx == INTC_EOI);
  assign rise     = irq & ~irq_q_reg;
  assign elig     = pending_reg & ~mask_reg;
  assign ack_fire = (state_reg == S_REQ) & int_ack & ~none;
  assign w1c      = (wr_en && (reg_idx == INTC_PEND)) ? io_din[N_IRQ-1:0] : '0;
  assign ack_clr  = ack_fire ? (N_IRQ'(1) << winner) : '0;
  assign clr      = w1c | ack_clr;
  assign unused_bits = ^{io_addr[1:0], io_din};

  intc_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req  (elig),
    .none (none),
    .id   (winner)
  );

`ifdef INTC_TRIGMODE_EN
  logic [N_IRQ-1:0] trig_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_reg <= '0;
    end else if (wr_en && (reg_idx == INTC_TRIG)) begin
      trig_reg <= io_din[N_IRQ-1:0];
    end
  end

  assign level_mode = trig_reg;
`else
  assign level_mode = '0;
`endif

  // A new edge beats a same-cycle clear; level lines simply follow the pin.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_line
      assign pending_next[gi] = level_mode[gi] ? irq[gi]
                              : ((pending_reg[gi] & ~clr[gi]) | rise[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      irq_q_reg   <= irq;
      pending_reg <= pending_next;
      if (wr_en && (reg_idx == INTC_MASK)) mask_reg <= io_din[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      intr       <= 1'b0;
      in_svc_reg <= 1'b0;
      vec_id_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!none) begin
            state_reg <= S_REQ;
            intr      <= 1'b1;
          end
        end
        S_REQ: begin
          // Losing every eligible request withdraws the interrupt, ack or not.
          if (none) begin
            state_reg <= S_IDLE;
            intr      <= 1'b0;
          end else if (int_ack) begin
            state_reg  <= S_SVC;
            intr       <= 1'b0;
            in_svc_reg <= 1'b1;
            vec_id_reg <= winner;
          end
        end
        S_SVC: begin
          if (eoi_wr) begin
            state_reg  <= S_IDLE;
            in_svc_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          intr      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      INTC_PEND: rd_data[N_IRQ-1:0] = pending_reg;
      INTC_MASK: rd_data[N_IRQ-1:0] = mask_reg;
      INTC_VEC: begin
        rd_data[31]       = in_svc_reg;
        rd_data[ID_W-1:0] = vec_id_reg;
      end
`ifdef INTC_TRIGMODE_EN
      INTC_TRIG: rd_data[N_IRQ-1:0] = level_mode;
`endif
      default: rd_data = '0;
    endcase
    io_dout = (io_cs & io_rd) ? rd_data : 32'h0;
  end

endmodule
